telemetry_bcd_scheduler: RTL and testbench

Frame-synchronous scheduler that converts the telemetry panel's binary signal values into fixed-width ASCII decimal digits using one shared, iterative double-dabble engine. It snapshots all values at frame start and processes the signals one at a time. Results are committed to a double-buffered output, so the panel's digit columns stay stable for the whole frame. It sits between the telemetry value sources and the telemetry text panel. It replaces one combinational divide/modulo chain per signal with one serial converter.

---
 rtl/telemetry_bcd_scheduler.sv | 128 ++++++++++++
 tb/tb_telemetry_bcd_scheduler.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/telemetry_bcd_scheduler.sv
// Frame-synchronous binary-to-ASCII decimal scheduler: snapshots all telemetry values at
// frame start, converts them one at a time with a shared double-dabble engine, commits atomically.
module telemetry_bcd_scheduler #(
  parameter int NUM_SIGNALS      = 7,
  parameter int VALUE_WIDTH      = 9,
  parameter int NUM_VALUE_DIGITS = 3
) (
  input  logic                                             clk,
  input  logic                                             reset_n,
  input  logic                                             frame_start,
  input  logic [NUM_SIGNALS-1:0][VALUE_WIDTH-1:0]          value_in,
  output logic [NUM_SIGNALS-1:0][NUM_VALUE_DIGITS-1:0][7:0] digits_out,
  output logic [NUM_SIGNALS-1:0]                           ovf_out,
  output logic                                             busy,
  output logic                                             done
);

  localparam int BCD_W = 4 * NUM_VALUE_DIGITS;
  localparam int CMP_W = VALUE_WIDTH + BCD_W;
  localparam int CNT_W = $clog2(VALUE_WIDTH + 1);
  localparam int IDX_W = (NUM_SIGNALS > 1) ? $clog2(NUM_SIGNALS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SIGNALS - 1);

  // 10^N - 1 always fits in 4N bits, so CMP_W is wide enough for a lossless compare.
  function automatic logic [CMP_W-1:0] calc_max_display();
    logic [CMP_W-1:0] p;
    p = CMP_W'(1);
    for (int i = 0; i < NUM_VALUE_DIGITS; i++) p = p * CMP_W'(10);
    return p - CMP_W'(1);
  endfunction

  localparam logic [CMP_W-1:0] MAX_DISPLAY = calc_max_display();

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, NEXT, COMMIT} state_t;

  state_t state, state_next;

  logic [NUM_SIGNALS-1:0][VALUE_WIDTH-1:0]           shadow;
  logic [VALUE_WIDTH-1:0]                            sreg;
  logic [BCD_W-1:0]                                  bcd;
  logic [BCD_W-1:0]                                  bcd_adj;
  logic [CMP_W-1:0]                                  shifted;
  logic [CNT_W-1:0]                                  cnt;
  logic [IDX_W-1:0]                                  idx;
  logic                                              sat;
  logic [NUM_SIGNALS-1:0][NUM_VALUE_DIGITS-1:0][7:0] back_buf;
  logic [NUM_SIGNALS-1:0]                            back_ovf;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (frame_start) state_next = LOAD;
      LOAD:    state_next = SHIFT;
      SHIFT:   if (cnt == CNT_W'(1)) state_next = NEXT;
      NEXT:    state_next = (idx == LAST_IDX) ? COMMIT : LOAD;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Add-3 correction followed by the joint left shift of {bcd, sreg}.
  always_comb begin
    bcd_adj = bcd;
    for (int d = 0; d < NUM_VALUE_DIGITS; d++) begin
      if (bcd[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
    end
    shifted = {bcd_adj, sreg} << 1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shadow     <= '0;
      sreg       <= '0;
      bcd        <= '0;
      cnt        <= '0;
      idx        <= '0;
      sat        <= 1'b0;
      back_buf   <= {(NUM_SIGNALS * NUM_VALUE_DIGITS){8'h30}};
      back_ovf   <= '0;
      digits_out <= {(NUM_SIGNALS * NUM_VALUE_DIGITS){8'h30}};
      ovf_out    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      done <= (state == COMMIT);
      case (state)
        IDLE: begin
          if (frame_start) begin
            shadow <= value_in;
            idx    <= '0;
          end
        end
        LOAD: begin
          sreg <= shadow[idx];
          bcd  <= '0;
          cnt  <= CNT_W'(VALUE_WIDTH);
          sat  <= ({{BCD_W{1'b0}}, shadow[idx]} > MAX_DISPLAY);
        end
        SHIFT: begin
          bcd  <= shifted[CMP_W-1:VALUE_WIDTH];
          sreg <= shifted[VALUE_WIDTH-1:0];
          cnt  <= cnt - CNT_W'(1);
        end
        NEXT: begin
          // Digit 0 is the most significant, i.e. the top nibble of bcd.
          for (int d = 0; d < NUM_VALUE_DIGITS; d++) begin
            back_buf[idx][d] <= sat ? 8'h39
                                    : 8'h30 + {4'h0, bcd[4*(NUM_VALUE_DIGITS-1-d) +: 4]};
          end
          back_ovf[idx] <= sat;
          if (idx != LAST_IDX) idx <= idx + IDX_W'(1);
        end
        COMMIT: begin
          digits_out <= back_buf;
          ovf_out    <= back_ovf;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_telemetry_bcd_scheduler.sv
// Scoreboard bench for telemetry_bcd_scheduler: expected frames are queued at frame_start
// and compared against digits_out/ovf_out/done timing when done pulses.
module tb_telemetry_bcd_scheduler;

  localparam int NS     = 7;
  localparam int VW     = 9;
  localparam int ND     = 3;
  localparam int ND_SAT = 2;
  localparam int LAT    = NS * (VW + 2) + 1;

  typedef logic [NS-1:0][VW-1:0] vec_t;
  typedef struct {
    logic [NS*ND*8-1:0] digits;
    logic [NS-1:0]      ovf;
    int                 due;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic frame_start = 1'b0;
  logic frame_start_sat = 1'b0;
  vec_t value_in = '0;
  vec_t value_in_sat = '0;

  logic [NS-1:0][ND-1:0][7:0]     digits_out;
  logic [NS-1:0]                  ovf_out;
  logic                           busy, done;
  logic [NS-1:0][ND_SAT-1:0][7:0] digits_sat;
  logic [NS-1:0]                  ovf_sat;
  logic                           busy_sat, done_sat;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];
  exp_t mon_e;

  vec_t           v;
  logic [255:0]   held;
  logic [255:0]   dg;
  logic [NS-1:0]  ov;
  logic [255:0]   zeros3;
  int             e0;
  bit             seen;
  int             basic_vals[NS] = '{0, 1, 9, 10, 99, 100, 511};
  int             sat_vals[NS]   = '{99, 100, 511, 0, 5, 250, 42};

  telemetry_bcd_scheduler #(.NUM_SIGNALS(NS), .VALUE_WIDTH(VW), .NUM_VALUE_DIGITS(ND)) dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .value_in(value_in),
    .digits_out(digits_out), .ovf_out(ovf_out), .busy(busy), .done(done)
  );

  telemetry_bcd_scheduler #(.NUM_SIGNALS(NS), .VALUE_WIDTH(VW), .NUM_VALUE_DIGITS(ND_SAT)) dut_sat (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start_sat), .value_in(value_in_sat),
    .digits_out(digits_sat), .ovf_out(ovf_sat), .busy(busy_sat), .done(done_sat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [255:0] act, input logic [255:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, expv);
    end
  endtask

  // Reference digits built with plain division, independent of the shift-add engine.
  function automatic void model(input vec_t vals, input int nd,
                                output logic [255:0] dgo, output logic [NS-1:0] ovo);
    int maxv, x, p;
    dgo = '0;
    ovo = '0;
    maxv = 1;
    for (int k = 0; k < nd; k++) maxv = maxv * 10;
    maxv = maxv - 1;
    for (int i = 0; i < NS; i++) begin
      x = int'(vals[i]);
      ovo[i] = (x > maxv);
      p = 1;
      for (int k = 0; k < nd - 1; k++) p = p * 10;
      for (int d = 0; d < nd; d++) begin
        dgo[(i*nd+d)*8 +: 8] = ovo[i] ? 8'h39 : 8'h30 + 8'((x / p) % 10);
        p = p / 10;
      end
    end
  endfunction

  task automatic applyStimulus(input vec_t vals);
    exp_t          e;
    logic [255:0]  mdg;
    logic [NS-1:0] mov;
    model(vals, ND, mdg, mov);
    e.digits = mdg[NS*ND*8-1:0];
    e.ovf    = mov;
    e.due    = cyc + 1 + LAT;
    sb.push_back(e);
    value_in    = vals;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  // n counts edges since the accepting edge; p1/p2 are edges at which extra pulses are sampled.
  task automatic waitDone(input logic [255:0] held_digits, input int change_n,
                          input int p1, input int p2);
    int  start, n;
    bit  ok;
    start = cyc;
    ok = 1'b0;
    for (int k = 0; k < LAT + 20; k++) begin
      n = cyc - start;
      if (done) begin
        checkOutput("busy_low_at_done", 256'(busy), 256'(0));
        ok = 1'b1;
        break;
      end
      checkOutput("busy_high", 256'(busy), 256'(1));
      checkOutput("digits_held", 256'(digits_out), held_digits);
      if (n == change_n) value_in[3] = 9'd7;
      frame_start = (n == p1 - 1) || (n == p2 - 1);
      @(negedge clk);
    end
    frame_start = 1'b0;
    if (!ok) checkOutput("done_timeout", 256'(0), 256'(1));
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        checkOutput("spurious_done", 256'(1), 256'(0));
      end else begin
        mon_e = sb.pop_front();
        checkOutput("digits", 256'(digits_out), 256'(mon_e.digits));
        checkOutput("ovf", 256'(ovf_out), 256'(mon_e.ovf));
        checkOutput("done_cycle", 256'(cyc), 256'(mon_e.due));
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    zeros3 = 256'({(NS*ND){8'h30}});

    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_digits", 256'(digits_out), zeros3);
    checkOutput("rst_ovf", 256'(ovf_out), 256'(0));
    checkOutput("rst_busy", 256'(busy), 256'(0));
    checkOutput("rst_done", 256'(done), 256'(0));
    reset_n = 1'b1;
    repeat (100) @(negedge clk);
    checkOutput("idle_digits", 256'(digits_out), zeros3);
    checkOutput("idle_ovf", 256'(ovf_out), 256'(0));
    checkOutput("idle_busy", 256'(busy), 256'(0));

    $display("[TB] basic conversion");
    for (int i = 0; i < NS; i++) v[i] = VW'(basic_vals[i]);
    applyStimulus(v);
    waitDone(zeros3, -100, -100, -100);
    model(v, ND, held, ov);

    $display("[TB] snapshot coherency and ignored frame_start pulses");
    for (int i = 0; i < NS; i++) v[i] = VW'($urandom_range(0, 511));
    v[3] = 9'd42;
    applyStimulus(v);
    waitDone(held, 20, 10, 78);
    model(v, ND, held, ov);
    @(negedge clk);
    for (int i = 0; i < NS; i++) v[i] = VW'($urandom_range(0, 511));
    v[0] = 9'd511;
    v[6] = 9'd0;
    applyStimulus(v);
    waitDone(held, -100, -100, -100);
    model(v, ND, held, ov);

    $display("[TB] reset mid-conversion");
    for (int i = 0; i < NS; i++) v[i] = VW'($urandom_range(1, 511));
    applyStimulus(v);
    for (int k = 0; k < 39; k++) begin
      checkOutput("busy_before_abort", 256'(busy), 256'(1));
      @(negedge clk);
    end
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    sb.delete();
    checkOutput("abort_digits", 256'(digits_out), zeros3);
    checkOutput("abort_ovf", 256'(ovf_out), 256'(0));
    checkOutput("abort_busy", 256'(busy), 256'(0));
    checkOutput("abort_done", 256'(done), 256'(0));
    repeat (100) @(negedge clk);
    checkOutput("abort_still_idle", 256'(busy), 256'(0));
    for (int i = 0; i < NS; i++) v[i] = VW'($urandom_range(0, 511));
    applyStimulus(v);
    waitDone(zeros3, -100, -100, -100);

    $display("[TB] saturation with two digits");
    for (int i = 0; i < NS; i++) value_in_sat[i] = VW'(sat_vals[i]);
    frame_start_sat = 1'b1;
    @(negedge clk);
    frame_start_sat = 1'b0;
    e0 = cyc;
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (done_sat) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("sat_done_seen", 256'(seen), 256'(1));
    checkOutput("sat_latency", 256'(cyc - e0), 256'(LAT));
    model(value_in_sat, ND_SAT, dg, ov);
    checkOutput("sat_digits", 256'(digits_sat), 256'(dg[NS*ND_SAT*8-1:0]));
    checkOutput("sat_ovf", 256'(ovf_sat), 256'(ov));
    checkOutput("sat_row1", 256'(digits_sat[1]), 256'(16'h3939));
    checkOutput("sat_row3", 256'(digits_sat[3]), 256'(16'h3030));

    repeat (5) @(negedge clk);
    checkOutput("sb_empty", 256'(sb.size()), 256'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
